// File: rtl/memory_access_arbiter_if.sv
// Bundles the two lanes' memory requests, the single data-memory port and the per-lane results.
// The master modport is the arbiter; the slave modport is the pipeline/memory side.
interface memory_access_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  MemWriteM1, MemWriteM2;
  logic [1:0]            ResultSrcM1, ResultSrcM2;
  logic [2:0]            AddressingControlM1, AddressingControlM2;
  logic [31:0]           ALUResultM1, ALUResultM2;
  logic [31:0]           WriteDataM1, WriteDataM2;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic [31:0]           ReadDataM1, ReadDataM2;
  logic                  StallM;

  modport master (
    input  MemWriteM1, MemWriteM2, ResultSrcM1, ResultSrcM2,
           AddressingControlM1, AddressingControlM2,
           ALUResultM1, ALUResultM2, WriteDataM1, WriteDataM2, mem_rdata,
    output mem_addr, mem_we, mem_be, mem_wdata, ReadDataM1, ReadDataM2, StallM
  );

  modport slave (
    output MemWriteM1, MemWriteM2, ResultSrcM1, ResultSrcM2,
           AddressingControlM1, AddressingControlM2,
           ALUResultM1, ALUResultM2, WriteDataM1, WriteDataM2, mem_rdata,
    input  mem_addr, mem_we, mem_be, mem_wdata, ReadDataM1, ReadDataM2, StallM
  );
endinterface

// File: rtl/memory_access_arbiter.sv
// Dual-lane memory stage: serialises two lanes onto one data-memory port (lane 1 first).
// Define MEM_PERF_CNT_EN to add the saturating ConflictCountM dual-access counter.
//   state  | meaning
//   IDLE   | serve lane 1 (or lane 2 alone); stall and move on if both lanes access memory
//   SECOND | serve lane 2 of a conflicting pair; lane 1 result comes from hold1_q
module memory_access_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  memory_access_arbiter_if.master bus
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  ConflictCountM
`endif
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t      state_q, state_d;
  logic [31:0] hold1_q;
  logic        ld1, ld2, act1, act2, serve1, serve2;
  logic [31:0] ext1, ext2;

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: byte_en = 4'b0001 << a;
      3'b001, 3'b101: byte_en = 4'b0011 << {a[1], 1'b0};
      default:        byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] align_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000, 3'b100: align_wdata = {4{wd[7:0]}};
      3'b001, 3'b101: align_wdata = {2{wd[15:0]}};
      default:        align_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] a,
                                          input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'h0, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'h0, h};
      default: extract = rd;
    endcase
  endfunction

  assign ld1  = (bus.ResultSrcM1 == 2'b01);
  assign ld2  = (bus.ResultSrcM2 == 2'b01);
  assign act1 = bus.MemWriteM1 | ld1;
  assign act2 = bus.MemWriteM2 | ld2;
  assign ext1 = extract(bus.AddressingControlM1, bus.ALUResultM1[1:0], bus.mem_rdata);
  assign ext2 = extract(bus.AddressingControlM2, bus.ALUResultM2[1:0], bus.mem_rdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold1_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (bus.StallM) hold1_q <= ld1 ? ext1 : 32'h0;
    end
  end

  always_comb begin
    state_d    = state_q;
    serve1     = 1'b0;
    serve2     = 1'b0;
    bus.StallM = 1'b0;
    case (state_q)
      IDLE: begin
        serve1 = act1;
        serve2 = act2 & ~act1;
        if (act1 & act2) begin
          bus.StallM = 1'b1;
          state_d    = SECOND;
        end
      end
      SECOND: begin
        serve2  = act2;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_addr   = '0;
    bus.mem_we     = 1'b0;
    bus.mem_be     = 4'b0000;
    bus.mem_wdata  = 32'h0;
    bus.ReadDataM1 = 32'h0;
    bus.ReadDataM2 = 32'h0;
    if (serve1) begin
      bus.mem_addr  = {bus.ALUResultM1[ADDR_WIDTH-1:2], 2'b00};
      bus.mem_we    = bus.MemWriteM1;
      bus.mem_be    = byte_en(bus.AddressingControlM1, bus.ALUResultM1[1:0]);
      bus.mem_wdata = bus.MemWriteM1 ? align_wdata(bus.AddressingControlM1, bus.WriteDataM1) : 32'h0;
    end else if (serve2) begin
      bus.mem_addr  = {bus.ALUResultM2[ADDR_WIDTH-1:2], 2'b00};
      // a reset landing in SECOND abandons lane 2, so its store must not reach memory
      bus.mem_we    = bus.MemWriteM2 & ~(rst & (state_q == SECOND));
      bus.mem_be    = byte_en(bus.AddressingControlM2, bus.ALUResultM2[1:0]);
      bus.mem_wdata = bus.MemWriteM2 ? align_wdata(bus.AddressingControlM2, bus.WriteDataM2) : 32'h0;
    end
    if (state_q == SECOND)  bus.ReadDataM1 = hold1_q;
    else if (serve1 & ld1)  bus.ReadDataM1 = ext1;
    if (serve2 & ld2)       bus.ReadDataM2 = ext2;
  end

`ifdef MEM_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (state_q == IDLE && state_d == SECOND && !(&cnt_q))
      cnt_q <= cnt_q + CNT_WIDTH'(1);
  end

  assign ConflictCountM = cnt_q;
`endif

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Self-checking bench for memory_access_arbiter: vector table, directed corner sequences,
// and randomized lane pairs checked against a transaction-level reference model.
module tb_memory_access_arbiter;

  typedef struct {
    logic        we;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
  } lane_t;

  typedef struct {
    lane_t       ln;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] mem     [0:1023] = '{default: 32'h0};
  logic [31:0] ref_mem [0:1023] = '{default: 32'h0};
`ifdef MEM_PERF_CNT_EN
  logic [31:0] conflict_cnt;
`endif

  memory_access_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  memory_access_arbiter #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MEM_PERF_CNT_EN
    ,
    .ConflictCountM (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[11:2]];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      for (int i = 0; i < 4; i++)
        if (bus.mem_be[i]) mem[bus.mem_addr[11:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    end
  end

  // ---------------- reference model (arithmetic on bytes, no RTL structure) ----------------
  function automatic logic [3:0] m_be(input logic [2:0] f3, input int a);
    if (f3 == 3'd0 || f3 == 3'd4) return 4'(1 << a);
    if (f3 == 3'd1 || f3 == 3'd5) return 4'(3 << ((a / 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3 == 3'd0 || f3 == 3'd4) return (wd & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1 || f3 == 3'd5) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input int a, input logic [31:0] w);
    logic [31:0] v;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = (w >> (8 * a)) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v - 32'h100;
      return v;
    end
    if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (w >> (16 * (a / 2))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
      return v;
    end
    return w;
  endfunction

  function automatic bit is_ld(input lane_t l);
    return l.rs == 2'b01;
  endfunction

  function automatic bit is_act(input lane_t l);
    return l.we || l.rs == 2'b01;
  endfunction

  task automatic ref_store(input lane_t l);
    logic [3:0]  be;
    logic [31:0] wd;
    be = m_be(l.f3, int'(l.addr % 4));
    wd = m_wdata(l.f3, l.wd);
    for (int i = 0; i < 4; i++)
      if (be[i]) ref_mem[l.addr[11:2]][8*i +: 8] = wd[8*i +: 8];
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_lanes(input lane_t l1, input lane_t l2);
    bus.MemWriteM1 = l1.we;  bus.ResultSrcM1 = l1.rs;  bus.AddressingControlM1 = l1.f3;
    bus.ALUResultM1 = l1.addr;  bus.WriteDataM1 = l1.wd;
    bus.MemWriteM2 = l2.we;  bus.ResultSrcM2 = l2.rs;  bus.AddressingControlM2 = l2.f3;
    bus.ALUResultM2 = l2.addr;  bus.WriteDataM2 = l2.wd;
  endtask

  // port checks for a lane being served this cycle
  task automatic chk_port(input string tag, input lane_t l);
    chk({tag, " addr"}, bus.mem_addr, l.addr & ~32'h3);
    chk({tag, " we"}, 32'(bus.mem_we), 32'(l.we));
    chk({tag, " be"}, 32'(bus.mem_be), 32'(m_be(l.f3, int'(l.addr % 4))));
    if (l.we) chk({tag, " wdata"}, bus.mem_wdata, m_wdata(l.f3, l.wd));
  endtask

  task automatic run_pair(input lane_t l1, input lane_t l2);
    logic [31:0] e1, e2;
    lane_t       s;
    if (is_act(l1) && is_act(l2)) begin
      e1 = is_ld(l1) ? m_load(l1.f3, int'(l1.addr % 4), ref_mem[l1.addr[11:2]]) : 32'h0;
      @(negedge clk); set_lanes(l1, l2); #1;
      chk("rnd stall1", 32'(bus.StallM), 32'd1);
      chk_port("rnd l1", l1);
      chk("rnd rd1 first", bus.ReadDataM1, e1);
      chk("rnd rd2 first", bus.ReadDataM2, 32'h0);
      if (l1.we) ref_store(l1);
      e2 = is_ld(l2) ? m_load(l2.f3, int'(l2.addr % 4), ref_mem[l2.addr[11:2]]) : 32'h0;
      @(negedge clk); #1;
      chk("rnd stall2", 32'(bus.StallM), 32'd0);
      chk_port("rnd l2", l2);
      chk("rnd rd1 held", bus.ReadDataM1, e1);
      chk("rnd rd2", bus.ReadDataM2, e2);
      if (l2.we) ref_store(l2);
    end else begin
      s = is_act(l1) ? l1 : l2;
      e1 = (is_act(l1) && is_ld(l1)) ? m_load(l1.f3, int'(l1.addr % 4), ref_mem[l1.addr[11:2]]) : 32'h0;
      e2 = (!is_act(l1) && is_ld(l2)) ? m_load(l2.f3, int'(l2.addr % 4), ref_mem[l2.addr[11:2]]) : 32'h0;
      @(negedge clk); set_lanes(l1, l2); #1;
      chk("rnd single stall", 32'(bus.StallM), 32'd0);
      if (is_act(s)) begin
        chk_port("rnd single", s);
        if (s.we) ref_store(s);
      end else begin
        chk("rnd idle we", 32'(bus.mem_we), 32'd0);
        chk("rnd idle be", 32'(bus.mem_be), 32'd0);
        chk("rnd idle addr", bus.mem_addr, 32'h0);
        chk("rnd idle wdata", bus.mem_wdata, 32'h0);
      end
      chk("rnd single rd1", bus.ReadDataM1, e1);
      chk("rnd single rd2", bus.ReadDataM2, e2);
    end
  endtask

  function automatic lane_t rnd_lane();
    lane_t       l;
    int          kind;
    logic [2:0]  f3s [8];
    logic [1:0]  nrs [3];
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    nrs = '{2'b00, 2'b10, 2'b11};
    kind   = $urandom_range(0, 2);
    l.we   = (kind == 2);
    l.rs   = (kind == 1) ? 2'b01 : nrs[$urandom_range(0, 2)];
    l.f3   = f3s[$urandom_range(0, 7)];
    l.addr = 32'h800 + 32'($urandom_range(0, 32'h3FF));
    l.wd   = $urandom;
    return l;
  endfunction

  // ---------------- stimulus ----------------
  lane_t bub;
  vec_t  vecs [18];

  initial begin
    lane_t a, b;

    bub = '{we: 1'b0, rs: 2'b00, f3: 3'b010, addr: 32'h0, wd: 32'h0};
    vecs[0]  = '{'{1'b1, 2'b00, 3'b010, 32'h200, 32'h80FF7F01}, 4'hF, 32'h80FF7F01, 32'h0};
    vecs[1]  = '{'{1'b1, 2'b00, 3'b010, 32'h100, 32'hDEADBEEF}, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{'{1'b0, 2'b01, 3'b010, 32'h102, 32'h0}, 4'hF, 32'h0, 32'hDEADBEEF};
    vecs[3]  = '{'{1'b0, 2'b01, 3'b000, 32'h200, 32'h0}, 4'h1, 32'h0, 32'h00000001};
    vecs[4]  = '{'{1'b0, 2'b01, 3'b000, 32'h201, 32'h0}, 4'h2, 32'h0, 32'h0000007F};
    vecs[5]  = '{'{1'b0, 2'b01, 3'b000, 32'h202, 32'h0}, 4'h4, 32'h0, 32'hFFFFFFFF};
    vecs[6]  = '{'{1'b0, 2'b01, 3'b100, 32'h203, 32'h0}, 4'h8, 32'h0, 32'h00000080};
    vecs[7]  = '{'{1'b0, 2'b01, 3'b000, 32'h203, 32'h0}, 4'h8, 32'h0, 32'hFFFFFF80};
    vecs[8]  = '{'{1'b0, 2'b01, 3'b001, 32'h200, 32'h0}, 4'h3, 32'h0, 32'h00007F01};
    vecs[9]  = '{'{1'b0, 2'b01, 3'b001, 32'h202, 32'h0}, 4'hC, 32'h0, 32'hFFFF80FF};
    vecs[10] = '{'{1'b0, 2'b01, 3'b101, 32'h203, 32'h0}, 4'hC, 32'h0, 32'h000080FF};
    vecs[11] = '{'{1'b0, 2'b01, 3'b010, 32'h201, 32'h0}, 4'hF, 32'h0, 32'h80FF7F01};
    vecs[12] = '{'{1'b0, 2'b01, 3'b011, 32'h202, 32'h0}, 4'hF, 32'h0, 32'h80FF7F01};
    vecs[13] = '{'{1'b0, 2'b01, 3'b110, 32'h200, 32'h0}, 4'hF, 32'h0, 32'h80FF7F01};
    vecs[14] = '{'{1'b1, 2'b00, 3'b000, 32'h301, 32'h123456AB}, 4'h2, 32'hABABABAB, 32'h0};
    vecs[15] = '{'{1'b1, 2'b10, 3'b001, 32'h303, 32'h1111CAFE}, 4'hC, 32'hCAFECAFE, 32'h0};
    vecs[16] = '{'{1'b0, 2'b10, 3'b010, 32'h200, 32'h55}, 4'h0, 32'h0, 32'h0};
    vecs[17] = '{'{1'b0, 2'b11, 3'b000, 32'h203, 32'h77}, 4'h0, 32'h0, 32'h0};

    rst = 1'b1;
    set_lanes(bub, bub);
    repeat (2) @(negedge clk);
    #1;
    chk("reset stall", 32'(bus.StallM), 32'd0);
    chk("reset rd1", bus.ReadDataM1, 32'h0);
    chk("reset we", 32'(bus.mem_we), 32'd0);
    @(negedge clk); rst = 1'b0;

    // single-lane vectors, applied on each lane with the other lane idle
    for (int i = 0; i < 18; i++) begin
      for (int ln = 1; ln <= 2; ln++) begin
        @(negedge clk);
        if (ln == 1) set_lanes(vecs[i].ln, bub); else set_lanes(bub, vecs[i].ln);
        #1;
        chk($sformatf("vec%0d/l%0d addr", i, ln), bus.mem_addr,
            (vecs[i].be == 4'h0) ? 32'h0 : (vecs[i].ln.addr & ~32'h3));
        chk($sformatf("vec%0d/l%0d we", i, ln), 32'(bus.mem_we), 32'(vecs[i].ln.we));
        chk($sformatf("vec%0d/l%0d be", i, ln), 32'(bus.mem_be), 32'(vecs[i].be));
        chk($sformatf("vec%0d/l%0d stall", i, ln), 32'(bus.StallM), 32'd0);
        if (vecs[i].ln.we || vecs[i].be == 4'h0)
          chk($sformatf("vec%0d/l%0d wdata", i, ln), bus.mem_wdata, vecs[i].wdata);
        chk($sformatf("vec%0d/l%0d rd served", i, ln),
            (ln == 1) ? bus.ReadDataM1 : bus.ReadDataM2, vecs[i].rd);
        chk($sformatf("vec%0d/l%0d rd other", i, ln),
            (ln == 1) ? bus.ReadDataM2 : bus.ReadDataM1, 32'h0);
      end
    end

    // lane-1 sb then lane-2 lbu to the same byte: lane 2 sees the new byte
    a = '{1'b1, 2'b00, 3'b000, 32'h103, 32'h000000AB};
    b = '{1'b0, 2'b01, 3'b100, 32'h103, 32'h0};
    @(negedge clk); set_lanes(a, b); #1;
    chk("sb/lbu stall", 32'(bus.StallM), 32'd1);
    chk("sb/lbu be1", 32'(bus.mem_be), 32'h8);
    chk("sb/lbu we1", 32'(bus.mem_we), 32'd1);
    @(negedge clk); #1;
    chk("sb/lbu stall2", 32'(bus.StallM), 32'd0);
    chk("sb/lbu we2", 32'(bus.mem_we), 32'd0);
    chk("sb/lbu rd2", bus.ReadDataM2, 32'h000000AB);
    chk("sb/lbu rd1", bus.ReadDataM1, 32'h0);

    // lb + lh to 0x202 with lane-1 result held across the stall
    a = '{1'b0, 2'b01, 3'b000, 32'h202, 32'h0};
    b = '{1'b0, 2'b01, 3'b001, 32'h202, 32'h0};
    @(negedge clk); set_lanes(a, b); #1;
    chk("lb/lh stall", 32'(bus.StallM), 32'd1);
    chk("lb/lh rd2 first", bus.ReadDataM2, 32'h0);
    @(negedge clk); #1;
    chk("lb/lh rd1 held", bus.ReadDataM1, 32'hFFFFFFFF);
    chk("lb/lh rd2", bus.ReadDataM2, 32'hFFFF80FF);
    @(negedge clk); set_lanes('{1'b0, 2'b01, 3'b101, 32'h202, 32'h0}, bub); #1;
    chk("lhu rd1", bus.ReadDataM1, 32'h000080FF);
    chk("lhu stall", 32'(bus.StallM), 32'd0);

    // two halfword stores into one word
    a = '{1'b1, 2'b00, 3'b001, 32'h300, 32'h00001234};
    b = '{1'b1, 2'b00, 3'b001, 32'h302, 32'h00005678};
    @(negedge clk); set_lanes(a, b); #1;
    chk("sh/sh be1", 32'(bus.mem_be), 32'h3);
    @(negedge clk); #1;
    chk("sh/sh be2", 32'(bus.mem_be), 32'hC);
    chk("sh/sh we2", 32'(bus.mem_we), 32'd1);
    @(negedge clk); set_lanes(bub, bub); #1;
    chk("sh/sh word", mem[32'h300 >> 2], 32'h56781234);

    // reset in SECOND abandons the lane-2 store
    a = '{1'b1, 2'b00, 3'b010, 32'h400, 32'h11111111};
    b = '{1'b1, 2'b00, 3'b010, 32'h404, 32'h22222222};
    @(negedge clk); set_lanes(a, b); #1;
    chk("rst2 stall", 32'(bus.StallM), 32'd1);
    @(negedge clk); rst = 1'b1; #1;
    chk("rst2 we blocked", 32'(bus.mem_we), 32'd0);
    @(negedge clk); rst = 1'b0; set_lanes(bub, bub); #1;
    chk("rst2 stall after", 32'(bus.StallM), 32'd0);
    chk("rst2 lane1 word", mem[32'h400 >> 2], 32'h11111111);
    chk("rst2 lane2 word", mem[32'h404 >> 2], 32'h0);
    a = '{1'b0, 2'b01, 3'b010, 32'h400, 32'h0};
    b = '{1'b0, 2'b01, 3'b010, 32'h404, 32'h0};
    @(negedge clk); set_lanes(a, b); #1;
    chk("rst2 idle stall", 32'(bus.StallM), 32'd1);
    @(negedge clk); #1;
    chk("rst2 rd1 held", bus.ReadDataM1, 32'h11111111);
    chk("rst2 rd2", bus.ReadDataM2, 32'h0);

`ifdef MEM_PERF_CNT_EN
    @(negedge clk); rst = 1'b1; set_lanes(bub, bub);
    @(negedge clk); rst = 1'b0; #1;
    chk("cnt reset", conflict_cnt, 32'd0);
    for (int p = 0; p < 3; p++) begin
      @(negedge clk); set_lanes(a, b);
      @(negedge clk);
    end
    @(negedge clk); set_lanes(bub, bub); #1;
    chk("cnt three", conflict_cnt, 32'd3);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("cnt cleared", conflict_cnt, 32'd0);
`endif

    for (int n = 0; n < 300; n++) run_pair(rnd_lane(), rnd_lane());

    @(negedge clk); set_lanes(bub, bub);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
